// File: rtl/range_frame_sequencer.sv
// range_frame_sequencer
//   Upstream feeder for the range-finder stage. It collects one frame of samples from a
//   valid/ready stream (in_last marks the final sample) into a small buffer. It then replays
//   the frame as a single gap-free burst on the finder's go/finish/data protocol.
//   A frame that would not fit in the buffer is dropped, and the sticky overflow flag is set.
//
//   Parameters
//     WIDTH       sample width (matches the range finder)
//     DEPTH       buffer depth in samples; power of two, >= 2
//
//   Ports
//     clock       single clock, all logic on the rising edge
//     reset       synchronous, active-high
//     in_data     input sample
//     in_valid    in_data is valid
//     in_last     final sample of the frame (only meaningful with in_valid)
//     in_ready    a beat is accepted this cycle when in_valid & in_ready
//     out_data    registered sample to the finder
//     out_go      registered go, high with the first sample of a burst
//     out_finish  registered finish, high with the last sample of a burst
//     busy        high while a burst is being replayed
//     overflow    sticky: a frame exceeded DEPTH and was dropped (cleared by reset)
//     frame_cnt   [RFS_FRAME_CNT_EN only] number of completed bursts, wraps at 16 bits
//
//   Optional feature macro: RFS_FRAME_CNT_EN adds the frame_cnt port and counter.
module range_frame_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_go,
  output logic             out_finish,
  output logic             busy,
  output logic             overflow
`ifdef RFS_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {FILL, DRAIN, DISCARD} state_t;

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             first;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             accept;

  // Ready depends only on the registered state and fill level.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      FILL:    in_ready = (count < FULL);
      DISCARD: in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Sample storage. It needs no reset because count decides which entries are valid.
  always_ff @(posedge clock) begin
    if (state == FILL && accept) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Main sequencer with registered outputs.
  // During DRAIN, 'first' marks the go cycle. Count stays at 1 across the go cycle of a
  // single-sample frame so that the finish cycle repeats s0 and go never coincides with finish.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      first      <= 1'b0;
      out_data   <= '0;
      out_go     <= 1'b0;
      out_finish <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          out_go     <= 1'b0;
          out_finish <= 1'b0;
          if (accept) begin
            if (in_last) begin
              state  <= DRAIN;
              busy   <= 1'b1;
              first  <= 1'b1;
              wr_ptr <= wr_ptr + PTR_ONE;
              count  <= count + CNT_ONE;
            end else if (count == FULL - CNT_ONE) begin
              // The last slot was filled without an end of frame, so drop the whole frame.
              state    <= DISCARD;
              overflow <= 1'b1;
              count    <= '0;
              wr_ptr   <= '0;
              rd_ptr   <= '0;
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
              count  <= count + CNT_ONE;
            end
          end
        end

        DRAIN: begin
          out_data <= mem[rd_ptr];
          if (first) begin
            out_go     <= 1'b1;
            out_finish <= 1'b0;
            first      <= 1'b0;
            if (count != CNT_ONE) begin
              rd_ptr <= rd_ptr + PTR_ONE;
              count  <= count - CNT_ONE;
            end
          end else begin
            out_go <= 1'b0;
            if (count == CNT_ONE) begin
              out_finish <= 1'b1;
              state      <= FILL;
              busy       <= 1'b0;
              count      <= '0;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
            end else begin
              out_finish <= 1'b0;
              rd_ptr     <= rd_ptr + PTR_ONE;
              count      <= count - CNT_ONE;
            end
          end
        end

        DISCARD: begin
          out_go     <= 1'b0;
          out_finish <= 1'b0;
          if (in_valid && in_last) begin
            state <= FILL;
          end
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef RFS_FRAME_CNT_EN
  // Counts at the same edge that raises out_finish, so the count already includes the
  // burst while finish is visible. Dropped frames never reach finish, so they are not counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= 16'd0;
    end else if (state == DRAIN && !first && count == CNT_ONE) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  // No frame counter in this build.
`endif

endmodule
